// File: rtl/utim64_pkg.sv
// rtl/utim64_pkg.sv - shared constants, state encoding and half-mask helper for the utim64 timer
package utim64_pkg;

    localparam int COUNTER_WIDTH  = 64;
    localparam int DQM_HALF_WIDTH = 32;

    typedef enum logic [1:0] {
        DISABLED = 2'h0,
        ARMED    = 2'h1,
        FIRED    = 2'h2
    } compState_t;

    // Merge new data into an old value; a half is replaced only when its mask bit is low
    function automatic logic [COUNTER_WIDTH-1:0] applyDqm(
        input logic [COUNTER_WIDTH-1:0] oldValue,
        input logic [COUNTER_WIDTH-1:0] newValue,
        input logic [1:0]               nDqm
    );
        logic [COUNTER_WIDTH-1:0] merged;
        merged = oldValue;
        if (!nDqm[0]) merged[DQM_HALF_WIDTH-1:0]             = newValue[DQM_HALF_WIDTH-1:0];
        if (!nDqm[1]) merged[COUNTER_WIDTH-1:DQM_HALF_WIDTH] = newValue[COUNTER_WIDTH-1:DQM_HALF_WIDTH];
        return merged;
    endfunction

endpackage

// File: rtl/utim64_dqm_reg.sv
// rtl/utim64_dqm_reg.sv - 64-bit register with write enable and active-low two-half mask
module utim64_dqm_reg
    import utim64_pkg::*;
(
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iWRITE,
    input  logic [1:0]               inDQM,
    input  logic [COUNTER_WIDTH-1:0] iDATA,
    output logic [COUNTER_WIDTH-1:0] oDATA
);

    logic [COUNTER_WIDTH-1:0] value;

    // Update only the unmasked halves on a write strobe
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            value <= '0;
        end else if (iWRITE) begin
            value <= applyDqm(value, iDATA, inDQM);
        end
    end

    assign oDATA = value;

endmodule

// File: rtl/utim64_comparator.sv
// rtl/utim64_comparator.sv - compare/interrupt unit for utim64; periodic re-arm under UTIM64_COMPARATOR_PERIODIC_EN
module utim64_comparator
    import utim64_pkg::*;
(
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iCONF_WRITE,
    input  logic        iCONF_ENA,
    input  logic        iCONF_PERIODIC,
    input  logic        iCOMP_WRITE,
    input  logic [1:0]  inCOMP_DQM,
    input  logic [63:0] iCOMP_VALUE,
    input  logic        iPERIOD_WRITE,
    input  logic [63:0] iPERIOD_VALUE,
    input  logic        iCOUNTER_WORKING,
    input  logic [63:0] iCOUNTER,
    input  logic        iIRQ_ACK,
    output logic        oIRQ_VALID,
    output logic        oOVERRUN,
    output logic        oARMED,
    output logic [63:0] oCOMPARE
);

    compState_t               state;
    compState_t               stateNext;
    logic [COUNTER_WIDTH-1:0] compare;
    logic [COUNTER_WIDTH-1:0] compareData;
    logic                     compareWrite;
    logic [1:0]               compareDqm;
    logic [COUNTER_WIDTH-1:0] period;
    logic                     periodicMode;
    logic                     irqValid;
    logic                     irqValidNext;
    logic                     overrun;
    logic                     overrunNext;
    logic                     match;

`ifdef UTIM64_COMPARATOR_PERIODIC_EN
    logic periodicNext;
    logic periodWrite;

    assign periodWrite  = iPERIOD_WRITE && (state != ARMED);
    assign periodicNext = (iCONF_WRITE && iCONF_ENA) ? iCONF_PERIODIC : periodicMode;

    utim64_dqm_reg uPeriodReg (
        .iCLOCK (iCLOCK),
        .inRESET(inRESET),
        .iWRITE (periodWrite),
        .inDQM  (2'b00),
        .iDATA  (iPERIOD_VALUE),
        .oDATA  (period)
    );

    // Mode is captured only when the comparator is enabled
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            periodicMode <= 1'b0;
        end else begin
            periodicMode <= periodicNext;
        end
    end
`else
    logic unusedPeriodicInputs;

    assign periodicMode         = 1'b0;
    assign period               = '0;
    assign unusedPeriodicInputs = ^{iPERIOD_WRITE, iPERIOD_VALUE, iCONF_PERIODIC};
`endif

    utim64_dqm_reg uCompareReg (
        .iCLOCK (iCLOCK),
        .inRESET(inRESET),
        .iWRITE (compareWrite),
        .inDQM  (compareDqm),
        .iDATA  (compareData),
        .oDATA  (compare)
    );

    // Exact equality against the live count; a stopped counter never matches
    assign match = (state == ARMED) && iCOUNTER_WORKING && (iCOUNTER == compare);

    // Next state, interrupt flags and compare-register write selection
    always_comb begin
        stateNext    = state;
        irqValidNext = irqValid;
        overrunNext  = overrun;
        compareWrite = 1'b0;
        compareDqm   = 2'b11;
        compareData  = iCOMP_VALUE;

        if (iIRQ_ACK && irqValid) begin
            irqValidNext = 1'b0;
        end

        if (iCONF_WRITE) begin
            // Config write takes priority; a coincident match is dropped
            overrunNext = 1'b0;
            if (iCONF_ENA) begin
                stateNext = ARMED;
            end else begin
                stateNext    = DISABLED;
                irqValidNext = 1'b0;
            end
        end else if (match) begin
            irqValidNext = 1'b1;
            if (irqValid && !iIRQ_ACK) begin
                overrunNext = 1'b1;
            end
            if (periodicMode) begin
                compareWrite = 1'b1;
                compareDqm   = 2'b00;
                compareData  = compare + period;
            end else begin
                stateNext = FIRED;
            end
        end

        // Software compare writes are blocked while armed, so they never race the re-arm update
        if (iCOMP_WRITE && (state != ARMED)) begin
            compareWrite = 1'b1;
            compareDqm   = inCOMP_DQM;
            compareData  = iCOMP_VALUE;
        end
    end

    // Comparator state register
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= DISABLED;
        end else begin
            state <= stateNext;
        end
    end

    // Interrupt request and sticky overrun flag
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            irqValid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            irqValid <= irqValidNext;
            overrun  <= overrunNext;
        end
    end

    assign oIRQ_VALID = irqValid;
    assign oOVERRUN   = overrun;
    assign oARMED     = (state == ARMED);
    assign oCOMPARE   = compare;

endmodule

// File: tb/tb_utim64_comparator.sv
// tb/tb_utim64_comparator.sv - self-checking bench for utim64_comparator with reference model
module tb_utim64_comparator;

`ifdef UTIM64_COMPARATOR_PERIODIC_EN
    localparam bit PBUILD = 1'b1;
`else
    localparam bit PBUILD = 1'b0;
`endif

    localparam int M_DIS = 0;
    localparam int M_ARM = 1;
    localparam int M_FIR = 2;

    logic        iCLOCK;
    logic        inRESET;
    logic        iCONF_WRITE;
    logic        iCONF_ENA;
    logic        iCONF_PERIODIC;
    logic        iCOMP_WRITE;
    logic [1:0]  inCOMP_DQM;
    logic [63:0] iCOMP_VALUE;
    logic        iPERIOD_WRITE;
    logic [63:0] iPERIOD_VALUE;
    logic        iCOUNTER_WORKING;
    logic [63:0] iCOUNTER;
    logic        iIRQ_ACK;
    logic        oIRQ_VALID;
    logic        oOVERRUN;
    logic        oARMED;
    logic [63:0] oCOMPARE;

    int          nChecks = 0;
    int          nPass   = 0;

    int          mState;
    logic [63:0] mCompare;
    logic [63:0] mPeriod;
    bit          mPeriodic;
    bit          mIrq;
    bit          mOverrun;

    utim64_comparator dut (
        .iCLOCK          (iCLOCK),
        .inRESET         (inRESET),
        .iCONF_WRITE     (iCONF_WRITE),
        .iCONF_ENA       (iCONF_ENA),
        .iCONF_PERIODIC  (iCONF_PERIODIC),
        .iCOMP_WRITE     (iCOMP_WRITE),
        .inCOMP_DQM      (inCOMP_DQM),
        .iCOMP_VALUE     (iCOMP_VALUE),
        .iPERIOD_WRITE   (iPERIOD_WRITE),
        .iPERIOD_VALUE   (iPERIOD_VALUE),
        .iCOUNTER_WORKING(iCOUNTER_WORKING),
        .iCOUNTER        (iCOUNTER),
        .iIRQ_ACK        (iIRQ_ACK),
        .oIRQ_VALID      (oIRQ_VALID),
        .oOVERRUN        (oOVERRUN),
        .oARMED          (oARMED),
        .oCOMPARE        (oCOMPARE)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    function automatic logic [66:0] dutVec();
        return {oIRQ_VALID, oOVERRUN, oARMED, oCOMPARE};
    endfunction

    function automatic logic [66:0] modelVec();
        return {mIrq, mOverrun, (mState == M_ARM), mCompare};
    endfunction

    task automatic modelReset();
        mState = M_DIS; mCompare = '0; mPeriod = '0; mPeriodic = 0; mIrq = 0; mOverrun = 0;
    endtask

    task automatic idle();
        iCONF_WRITE = 0; iCONF_ENA = 0; iCONF_PERIODIC = 0;
        iCOMP_WRITE = 0; inCOMP_DQM = 2'b11; iCOMP_VALUE = '0;
        iPERIOD_WRITE = 0; iPERIOD_VALUE = '0; iIRQ_ACK = 0;
    endtask

    // Advance one clock; the model follows the rules for the inputs presently driven
    task automatic step();
        bit          hit;
        int          nState;
        logic [63:0] nCompare;
        logic [63:0] nPeriod;
        bit          nPeriodic, nIrq, nOverrun;
        hit = (mState == M_ARM) && iCOUNTER_WORKING && (iCOUNTER == mCompare);
        nState = mState; nCompare = mCompare; nPeriod = mPeriod;
        nPeriodic = mPeriodic; nIrq = mIrq; nOverrun = mOverrun;
        if (iIRQ_ACK && mIrq) nIrq = 0;
        if (iCONF_WRITE) begin
            nOverrun = 0;
            if (iCONF_ENA) begin
                nState = M_ARM;
                nPeriodic = PBUILD && iCONF_PERIODIC;
            end else begin
                nState = M_DIS;
                nIrq = 0;
            end
        end else if (hit) begin
            if (mIrq && !iIRQ_ACK) nOverrun = 1;
            nIrq = 1;
            if (mPeriodic) nCompare = mCompare + mPeriod;
            else nState = M_FIR;
        end
        if (iCOMP_WRITE && mState != M_ARM) begin
            if (!inCOMP_DQM[0]) nCompare[31:0]  = iCOMP_VALUE[31:0];
            if (!inCOMP_DQM[1]) nCompare[63:32] = iCOMP_VALUE[63:32];
        end
        if (PBUILD && iPERIOD_WRITE && mState != M_ARM) nPeriod = iPERIOD_VALUE;
        @(posedge iCLOCK);
        #1;
        mState = nState; mCompare = nCompare; mPeriod = nPeriod;
        mPeriodic = nPeriodic; mIrq = nIrq; mOverrun = nOverrun;
    endtask

    task automatic configure(input bit ena, input bit periodic);
        idle();
        iCONF_WRITE = 1; iCONF_ENA = ena; iCONF_PERIODIC = periodic;
        step();
        idle();
    endtask

    task automatic writeCompare(input logic [63:0] v, input logic [1:0] ndqm);
        idle();
        iCOMP_WRITE = 1; iCOMP_VALUE = v; inCOMP_DQM = ndqm;
        step();
        idle();
    endtask

    task automatic writePeriod(input logic [63:0] v);
        idle();
        iPERIOD_WRITE = 1; iPERIOD_VALUE = v;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        iCOUNTER_WORKING = 0; iCOUNTER = '0;
        inRESET = 0;
        repeat (3) @(posedge iCLOCK);
        #1;
        inRESET = 1;
        modelReset();
        nChecks++;
        if (dutVec() !== 67'd0) $display("FAIL reset_state: got %h want %h", dutVec(), 67'd0);
        else nPass++;
    endtask

    task automatic test_oneshot();
        int irqCount;
        configure(0, 0);
        writeCompare(64'h100, 2'b00);
        configure(1, 0);
        iCOUNTER_WORKING = 1;
        irqCount = 0;
        for (int c = 0; c <= 'h104; c++) begin
            iCOUNTER = 64'(c);
            step();
            if (oIRQ_VALID && c == 'h100) irqCount++;
            nChecks++;
            if (dutVec() !== modelVec()) $display("FAIL oneshot_run c=%0h: got %h want %h", c, dutVec(), modelVec());
            else nPass++;
        end
        nChecks++;
        if (irqCount != 1 || oARMED !== 1'b0) $display("FAIL oneshot_fire: got irq=%0d armed=%b want irq=1 armed=0", irqCount, oARMED);
        else nPass++;
        iIRQ_ACK = 1;
        step();
        iIRQ_ACK = 0;
        nChecks++;
        if (oIRQ_VALID !== 1'b0) $display("FAIL oneshot_ack: got %b want 0", oIRQ_VALID);
        else nPass++;
        iCOUNTER = 64'h100;
        repeat (2) step();
        nChecks++;
        if (oIRQ_VALID !== 1'b0 || dutVec() !== modelVec()) $display("FAIL oneshot_no_second: got %h want %h", dutVec(), modelVec());
        else nPass++;
    endtask

    task automatic test_periodic();
        int irqCount;
        configure(0, 0);
        writeCompare(64'h10, 2'b00);
        writePeriod(64'h10);
        configure(1, 1);
        iCOUNTER_WORKING = 1;
        irqCount = 0;
        for (int c = 0; c <= 'h42; c++) begin
            iCOUNTER = 64'(c);
            iIRQ_ACK = mIrq && (c < 'h30);
            step();
            if (c == 'h10 || c == 'h20 || c == 'h30) irqCount += oIRQ_VALID;
            nChecks++;
            if (dutVec() !== modelVec()) $display("FAIL periodic_run c=%0h: got %h want %h", c, dutVec(), modelVec());
            else nPass++;
        end
        iIRQ_ACK = 0;
        nChecks++;
        if (irqCount != (PBUILD ? 3 : 1)) $display("FAIL periodic_count: got %0d want %0d", irqCount, PBUILD ? 3 : 1);
        else nPass++;
        nChecks++;
        if (oOVERRUN !== PBUILD || oCOMPARE !== (PBUILD ? 64'h50 : 64'h10))
            $display("FAIL periodic_overrun: got ovr=%b cmp=%h want ovr=%b cmp=%h", oOVERRUN, oCOMPARE, PBUILD, PBUILD ? 64'h50 : 64'h10);
        else nPass++;
    endtask

    task automatic test_dqm();
        configure(0, 0);
        writeCompare(64'hAAAA_AAAA_BBBB_BBBB, 2'b00);
        writeCompare(64'h1111_1111_2222_2222, 2'b10);
        nChecks++;
        if (oCOMPARE !== 64'hAAAA_AAAA_2222_2222) $display("FAIL dqm_low: got %h want %h", oCOMPARE, 64'hAAAA_AAAA_2222_2222);
        else nPass++;
        writeCompare(64'h3333_3333_4444_4444, 2'b01);
        nChecks++;
        if (oCOMPARE !== 64'h3333_3333_2222_2222) $display("FAIL dqm_high: got %h want %h", oCOMPARE, 64'h3333_3333_2222_2222);
        else nPass++;
        iCOUNTER_WORKING = 0;
        configure(1, 0);
        writeCompare(64'h5555_5555_6666_6666, 2'b00);
        nChecks++;
        if (oCOMPARE !== 64'h3333_3333_2222_2222) $display("FAIL dqm_armed_ignored: got %h want %h", oCOMPARE, 64'h3333_3333_2222_2222);
        else nPass++;
    endtask

    task automatic test_wrap();
        logic [63:0] want;
        configure(0, 0);
        writeCompare(64'hFFFF_FFFF_FFFF_FFF0, 2'b00);
        writePeriod(64'h20);
        configure(1, 1);
        iCOUNTER_WORKING = 1;
        iCOUNTER = 64'hFFFF_FFFF_FFFF_FFF0;
        step();
        want = PBUILD ? 64'h10 : 64'hFFFF_FFFF_FFFF_FFF0;
        nChecks++;
        if (oIRQ_VALID !== 1'b1 || oCOMPARE !== want) $display("FAIL wrap: got irq=%b cmp=%h want irq=1 cmp=%h", oIRQ_VALID, oCOMPARE, want);
        else nPass++;
        iCOUNTER = 64'h5;
        iIRQ_ACK = 1;
        step();
        iIRQ_ACK = 0;
    endtask

    task automatic test_simultaneous();
        configure(0, 0);
        writeCompare(64'h50, 2'b00);
        configure(1, 0);
        iCOUNTER_WORKING = 1;
        iCOUNTER = 64'h50;
        step();
        configure(1, 0);
        iCOUNTER = 64'h50;
        iIRQ_ACK = 1;
        step();
        iIRQ_ACK = 0;
        nChecks++;
        if (oIRQ_VALID !== 1'b1 || oOVERRUN !== 1'b0) $display("FAIL match_and_ack: got irq=%b ovr=%b want irq=1 ovr=0", oIRQ_VALID, oOVERRUN);
        else nPass++;
        iIRQ_ACK = 1;
        iCOUNTER = 64'h0;
        step();
        iIRQ_ACK = 0;
        configure(1, 0);
        iCOUNTER = 64'h50;
        iCONF_WRITE = 1; iCONF_ENA = 0;
        step();
        idle();
        nChecks++;
        if (oIRQ_VALID !== 1'b0 || oARMED !== 1'b0 || dutVec() !== modelVec())
            $display("FAIL config_beats_match: got %h want %h", dutVec(), modelVec());
        else nPass++;
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 1500; i++) begin
            idle();
            if ($urandom_range(0, 15) == 0) begin
                iCONF_WRITE = 1; iCONF_ENA = ($urandom_range(0, 3) != 0); iCONF_PERIODIC = 1'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                iCOMP_WRITE = 1; inCOMP_DQM = 2'($urandom);
                iCOMP_VALUE = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 'h3F));
            end
            if ($urandom_range(0, 7) == 0) begin
                iPERIOD_WRITE = 1; iPERIOD_VALUE = 64'($urandom_range(0, 8));
            end
            iCOUNTER_WORKING = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 9))
                0: iCOUNTER = mCompare;
                1: iCOUNTER = 64'($urandom_range(0, 'h3F));
                default: if (iCOUNTER_WORKING) iCOUNTER = iCOUNTER + 64'd1;
            endcase
            iIRQ_ACK = ($urandom_range(0, 2) == 0);
            step();
            nChecks++;
            if (dutVec() !== modelVec()) $display("FAIL random_cycle %0d: got %h want %h", i, dutVec(), modelVec());
            else nPass++;
        end
        idle();
    endtask

    task automatic test_reset_midrequest();
        configure(0, 0);
        writeCompare(64'h7, 2'b00);
        configure(1, 0);
        iCOUNTER_WORKING = 1;
        iCOUNTER = 64'h7;
        step();
        nChecks++;
        if (oIRQ_VALID !== 1'b1) $display("FAIL reset_setup_irq: got %b want 1", oIRQ_VALID);
        else nPass++;
        #1;
        inRESET = 0;
        #1;
        modelReset();
        nChecks++;
        if (dutVec() !== 67'd0) $display("FAIL reset_async: got %h want %h", dutVec(), 67'd0);
        else nPass++;
        #1;
        inRESET = 1;
        for (int c = 0; c < 12; c++) begin
            iCOUNTER = 64'(c);
            step();
            nChecks++;
            if (oIRQ_VALID !== 1'b0 || dutVec() !== modelVec()) $display("FAIL reset_no_irq c=%0d: got %h want %h", c, dutVec(), modelVec());
            else nPass++;
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_oneshot();
        test_periodic();
        test_dqm();
        test_wrap();
        test_simultaneous();
        test_back_to_back_random();
        test_reset_midrequest();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/utim64_comparator.md
# utim64_comparator

Compare/interrupt unit for the utim64 64-bit timer. It sits downstream of `main_counter` and consumes its running count and working flag. It holds a software-written 64-bit compare value and raises a level interrupt request when the counter reaches it. The request is held through a valid/ack handshake with the interrupt controller; optionally the compare value re-arms itself by a programmed period.

## Interface
Parameters:
- none (widths fixed: counter 64 bit, DQM 2 bit = two 32-bit halves)

Ports (one clock; reset is asynchronous and active-low):
- iCLOCK  in  1  system clock, all state on rising edge
- inRESET  in  1  asynchronous active-low reset
- iCONF_WRITE  in  1  config write strobe
- iCONF_ENA  in  1  config: comparator enable
- iCONF_PERIODIC  in  1  config: 1 = periodic, 0 = one-shot (ignored without macro)
- iCOMP_WRITE  in  1  compare-value write strobe
- inCOMP_DQM  in  2  active-low half mask: [0] = bits 31:0, [1] = bits 63:32
- iCOMP_VALUE  in  64  compare-value write data
- iPERIOD_WRITE  in  1  period write strobe (macro only)
- iPERIOD_VALUE  in  64  period write data (macro only)
- iCOUNTER_WORKING  in  1  main counter running flag
- iCOUNTER  in  64  main counter value
- iIRQ_ACK  in  1  interrupt acknowledge from controller
- oIRQ_VALID  out  1  interrupt request
- oOVERRUN  out  1  sticky: match occurred while request still pending
- oARMED  out  1  comparator state is ARMED
- oCOMPARE  out  64  current compare value

## Operation
- Reset: state DISABLED, compare = 0, period = 0, periodic = 0, oIRQ_VALID = 0, oOVERRUN = 0, oARMED = 0, oCOMPARE = 0.
- States: DISABLED, ARMED, FIRED.
  - iCONF_WRITE with iCONF_ENA = 1 goes to ARMED from any state, latches periodic, clears oOVERRUN.
  - iCONF_WRITE with iCONF_ENA = 0 goes to DISABLED and clears oIRQ_VALID and oOVERRUN.
- Match = state ARMED && iCOUNTER_WORKING && iCOUNTER == compare. The test is exact equality.
- On match:
  - One-shot: go to FIRED; compare unchanged.
  - Periodic: stay ARMED; compare <= compare + period, modulo 2^64 (the carry out is discarded).
- FIRED is left only by a config write.
- Compare write is accepted only in DISABLED or FIRED; it is ignored in ARMED. Each half is updated only when its inCOMP_DQM bit = 0.
- Period write is accepted only when not ARMED; it writes the full 64 bits.
- Interrupt:
  - A match sets oIRQ_VALID.
  - iIRQ_ACK while oIRQ_VALID = 1 clears it.
  - A match while oIRQ_VALID = 1 and no ack in the same cycle sets oOVERRUN.
- Simultaneous events:
  - Match and ack in the same cycle: oIRQ_VALID stays 1 and no overrun is set.
  - Config write and match in the same cycle: the config write wins and the match is discarded.
- Counter stopped (iCOUNTER_WORKING = 0): no match, even if the values are equal.
- Compare below the current count: the match occurs only after the counter wraps through 2^64.
- Periodic with period = 0: the compare value is unchanged. No further match occurs unless the counter wraps or is rewritten.

## Timing
- Match is evaluated combinationally from the current-cycle iCOUNTER and the registered compare value.
- oIRQ_VALID, oOVERRUN, oARMED and oCOMPARE are registered. They update one cycle after the match or write edge.
- Ack: oIRQ_VALID is low in the cycle after iIRQ_ACK is sampled high.
- iIRQ_ACK while oIRQ_VALID = 0 is ignored.
- Reset asserted mid-request drops every output to its reset value immediately (asynchronous).

## Configuration
- UTIM64_COMPARATOR_PERIODIC_EN
  - Defined: the period register, iPERIOD_WRITE, iPERIOD_VALUE and iCONF_PERIODIC are functional, and periodic re-arm is as above.
  - Undefined: the period register is removed, iPERIOD_* and iCONF_PERIODIC are ignored, and every match is one-shot (ARMED to FIRED).
  - Port list is identical in both builds.

## Structure
- Shared package `utim64_pkg`:
  - state encoding constants DISABLED = 2'h0, ARMED = 2'h1, FIRED = 2'h2
  - counter width 64 and DQM half width 32
- Sub-module `utim64_dqm_reg`: 64-bit register with active-low 2-bit half mask and write-enable. It is used for the compare value and is reusable for the period register.

## Test plan
- One-shot:
  - Stimulus: write compare = 0x100 with DQM = 2'b00, enable with periodic = 0, run the counter from 0.
  - Response: oIRQ_VALID rises the cycle after iCOUNTER = 0x100 and oARMED falls. Ack clears it next cycle and no second IRQ follows.
- Periodic (macro on):
  - Stimulus: compare = 0x10, period = 0x10, enable periodic.
  - Response: IRQs at counts 0x10, 0x20, 0x30; oCOMPARE steps by 0x10. Leaving one unacked through the next match sets oOVERRUN.
- DQM:
  - Stimulus: compare = 0xAAAA_AAAA_BBBB_BBBB, then write 0x1111_1111_2222_2222 with DQM = 2'b10.
  - Response: oCOMPARE = 0xAAAA_AAAA_2222_2222. A write attempted while ARMED leaves it unchanged.
- Wrap:
  - Stimulus: compare = 0xFFFF_FFFF_FFFF_FFF0, period = 0x20, counter reaching 0xFFFF_FFFF_FFFF_FFF0.
  - Response: IRQ fires and oCOMPARE = 0x0000_0000_0000_0010.
- Simultaneous events:
  - Match and ack in the same cycle leave oIRQ_VALID = 1 and oOVERRUN = 0.
  - Config disable and match in the same cycle leave oIRQ_VALID = 0 and the state DISABLED.
- Reset: assert inRESET while oIRQ_VALID = 1 -> all outputs 0 immediately; after release, no IRQ until re-enabled.
